// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between fetch (read-only) and the memory stage.
// Round-robin arbitration, fixed-latency RAM sequencing, and an address range check.
module dmem_port_arbiter #(
  parameter int DATA_WID    = 8,
  parameter int ADDR_WID    = 8,
  parameter int MEM_SIZE    = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_WID-1:0] if_addr,
  output logic                if_ready,
  output logic [DATA_WID-1:0] if_rdata,
  output logic                if_error,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_WID-1:0] mem_addr,
  input  logic [DATA_WID-1:0] mem_wdata,
  output logic                mem_ready,
  output logic [DATA_WID-1:0] mem_rdata,
  output logic                mem_error,
  output logic                ram_en,
  output logic                ram_we,
  output logic [ADDR_WID-1:0] ram_addr,
  output logic [DATA_WID-1:0] ram_wdata,
  input  logic [DATA_WID-1:0] ram_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic {GNT_IF, GNT_MEM} grant_t;

  localparam logic [ADDR_WID:0] LP_MEM_SIZE = (ADDR_WID + 1)'(MEM_SIZE);
  localparam logic [3:0]        LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              r_state;
  grant_t              r_last_grant;
  grant_t              r_grant;
  logic [3:0]          r_cnt;

  grant_t              w_grant;
  logic                w_any;
  logic [ADDR_WID-1:0] w_addr;
  logic                w_we;
  logic                w_bad;

  always_comb begin
    w_any   = if_req | mem_req;
    // On a tie the requester that was not served last wins.
    w_grant = (mem_req && (!if_req || r_last_grant == GNT_IF)) ? GNT_MEM : GNT_IF;
    w_addr  = (w_grant == GNT_MEM) ? mem_addr : if_addr;
    w_we    = (w_grant == GNT_MEM) && mem_we;
    w_bad   = {1'b0, w_addr} >= LP_MEM_SIZE;
  end

  assign busy = (r_state != S_IDLE);

  // NOTE: every register here is updated with <= so all reads in this block see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= GNT_MEM;
      r_grant      <= GNT_IF;
      r_cnt        <= '0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      if_ready     <= 1'b0;
      if_rdata     <= '0;
      if_error     <= 1'b0;
      mem_ready    <= 1'b0;
      mem_rdata    <= '0;
      mem_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant;
            ram_addr     <= w_addr;
            ram_wdata    <= mem_wdata;
            if (w_bad) begin
              // Out-of-range: complete immediately, the RAM is never enabled.
              r_state <= S_DONE;
              if (w_grant == GNT_MEM) begin
                mem_ready <= 1'b1;
                mem_error <= 1'b1;
                mem_rdata <= '0;
              end else begin
                if_ready <= 1'b1;
                if_error <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              r_state <= S_ACCESS;
              r_cnt   <= LP_CNT_INIT;
              ram_en  <= 1'b1;
              ram_we  <= w_we;
            end
          end
        end

        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            if (r_grant == GNT_MEM) begin
              mem_ready <= 1'b1;
              mem_error <= 1'b0;
              if (!ram_we) mem_rdata <= ram_rdata;
            end else begin
              if_ready <= 1'b1;
              if_error <= 1'b0;
              if_rdata <= ram_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_DONE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized rounds
// scored against a transaction-level model of arbitration order, latency and memory contents.
module tb_dmem_port_arbiter;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int MSZ  = 128;
  localparam int WAIT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_ready, if_error, mem_ready, mem_error;
  logic [DW-1:0] if_rdata, mem_rdata;
  logic          ram_en, ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dmem_port_arbiter #(
    .DATA_WID(DW), .ADDR_WID(AW), .MEM_SIZE(MSZ), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_error(if_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Simple RAM behind the port: synchronous write, combinational read.
  logic [DW-1:0] ram [0:255];
  logic          tb_clr;
  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (ram_en && ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_addr];

  // RAM-side activity monitor (sampled at the edge, so pre-update values).
  int            en_cnt = 0;
  int            we_cnt = 0;
  logic [AW-1:0] en_addr = '0;
  logic [DW-1:0] en_wdata = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt++;
      if (ram_we) we_cnt++;
      en_addr  = ram_addr;
      en_wdata = ram_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] ref_mem [0:255];
  bit            m_last_mem;
  logic [DW-1:0] exp_if_rd, exp_mem_rd;

  task automatic model_reset();
    m_last_mem = 1'b1;
    exp_if_rd  = '0;
    exp_mem_rd = '0;
  endtask

  function automatic int lat(input logic [AW-1:0] a);
    return (int'(a) >= MSZ) ? 1 : WAIT + 1;
  endfunction

  task automatic check_ram(input string who, input bit err, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int en0, input int we0);
    check({who, "_en_cycles"}, en_cnt - en0, err ? 0 : WAIT);
    check({who, "_we_cycles"}, we_cnt - we0, (!err && we) ? WAIT : 0);
    if (!err) check({who, "_ram_addr"}, en_addr, a);
    if (!err && we) check({who, "_ram_wdata"}, en_wdata, wd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {if_ready, mem_ready, if_error, mem_error, ram_en, ram_we, busy}, 0);
    check({tag, "_rdata"}, {if_rdata, mem_rdata}, 0);
    check({tag, "_ram_bus"}, {ram_addr, ram_wdata}, 0);
  endtask

  // One arbitration round: called at a negedge with the DUT idle; returns at a negedge, idle.
  task automatic run_round(input bit f_act, input logic [AW-1:0] f_addr,
                           input bit m_act, input bit m_we, input logic [AW-1:0] m_addr,
                           input logic [DW-1:0] m_wd, input bit f_drop);
    int            f_at, m_at, en0, we0;
    int            budget;
    bit            mem_first, f_err, m_err, f_done, m_done;
    logic [DW-1:0] f_rd, m_rd;
    f_at = -1; m_at = -1;
    f_rd = '0; m_rd = '0;
    f_err = int'(f_addr) >= MSZ;
    m_err = int'(m_addr) >= MSZ;
    budget = 2 * (WAIT + 2) + 6;
    mem_first = m_act && (!f_act || !m_last_mem);

    // Predict service order, completion cycle and data at transaction level.
    if (mem_first) begin
      m_at = lat(m_addr);
      if (m_err) m_rd = '0;
      else if (m_we) begin ref_mem[m_addr] = m_wd; m_rd = exp_mem_rd; end
      else m_rd = ref_mem[m_addr];
      exp_mem_rd = m_rd;
      m_last_mem = 1'b1;
    end
    if (f_act) begin
      f_at = (mem_first ? m_at + 1 : 0) + lat(f_addr);
      f_rd = f_err ? '0 : ref_mem[f_addr];
      exp_if_rd = f_rd;
      m_last_mem = 1'b0;
    end
    if (m_act && !mem_first) begin
      m_at = f_at + 1 + lat(m_addr);
      if (m_err) m_rd = '0;
      else if (m_we) begin ref_mem[m_addr] = m_wd; m_rd = exp_mem_rd; end
      else m_rd = ref_mem[m_addr];
      exp_mem_rd = m_rd;
      m_last_mem = 1'b1;
    end

    if_req = f_act; if_addr = f_addr;
    mem_req = m_act; mem_we = m_we; mem_addr = m_addr; mem_wdata = m_wd;
    en0 = en_cnt; we0 = we_cnt;
    f_done = !f_act; m_done = !m_act;

    for (int n = 1; n <= budget && !(f_done && m_done); n++) begin
      @(negedge clk);
      if (f_drop && n == 2) if_req = 1'b0;
      if (if_ready) begin
        check("if_ready_cycle", n, f_at);
        check("if_rdata", if_rdata, f_rd);
        check("if_error", if_error, f_err);
        check_ram("if", f_err, 1'b0, f_addr, '0, en0, we0);
        f_done = 1'b1; if_req = 1'b0;
        en0 = en_cnt; we0 = we_cnt;
      end
      if (mem_ready) begin
        check("mem_ready_cycle", n, m_at);
        check("mem_rdata", mem_rdata, m_rd);
        check("mem_error", mem_error, m_err);
        check_ram("mem", m_err, m_we, m_addr, m_wd, en0, we0);
        m_done = 1'b1; mem_req = 1'b0;
        en0 = en_cnt; we0 = we_cnt;
      end
    end
    check("if_completed", f_done, 1);
    check("mem_completed", m_done, 1);
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    check("idle_after_round", {busy, if_ready, mem_ready}, 0);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'(8'h80 + $urandom_range(0, 127));
    if (r == 1) return ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
    return 8'($urandom_range(0, 15));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tb_clr = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    tb_clr = 1'b0;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Simultaneous requests after reset: fetch first, then mem; repeats alternate the same way.
    run_round(1'b1, 8'h10, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0);
    run_round(1'b1, 8'h10, 1'b1, 1'b0, 8'h08, 8'h00, 1'b0);

    // Memory-stage write then read.
    run_round(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 8'h33, 1'b0);
    run_round(1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0);

    // Out-of-range write must not alias onto 0x19.
    run_round(1'b0, 8'h00, 1'b1, 1'b1, 8'h19, 8'h5A, 1'b0);
    run_round(1'b0, 8'h00, 1'b1, 1'b1, 8'h99, 8'hC7, 1'b0);
    run_round(1'b0, 8'h00, 1'b1, 1'b0, 8'h19, 8'h00, 1'b0);
    run_round(1'b1, 8'h19, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Range boundary on both ports.
    run_round(1'b0, 8'h00, 1'b1, 1'b1, 8'h7F, 8'hE1, 1'b0);
    run_round(1'b1, 8'h7F, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    run_round(1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 8'h00, 1'b0);
    run_round(1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Fetch abandons its request mid-access; the transfer still completes.
    run_round(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Reset in the second ACCESS cycle of a write.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h04; mem_wdata = 8'h44;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort_mid_access", {busy, ram_en, ram_we}, 3'b111);
    rst_n = 1'b0; mem_req = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      check("abort_quiet", {busy, if_ready, mem_ready}, 0);
    end
    run_round(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 8'h4C, 1'b0);
    run_round(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Randomized rounds.
    for (int r = 0; r < 200; r++) begin
      int            k;
      bit            fa, ma, mw;
      logic [AW-1:0] f_a, m_a;
      logic [DW-1:0] wd;
      k   = $urandom_range(1, 3);
      fa  = (k & 1) != 0;
      ma  = (k & 2) != 0;
      mw  = $urandom_range(0, 1) == 1;
      f_a = rand_addr();
      m_a = rand_addr();
      wd  = 8'($urandom_range(0, 255));
      run_round(fa, f_a, ma, mw, m_a, wd, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
